hazard_unit: RTL
================

# hazard_unit

Pipeline hazard detector that produces the pause/unpause request pulses consumed by the pipeline controller (`ctrl`), which turns them into the global `pause`/`flush` levels. It detects load-use dependencies between ID and EX and multi-cycle mul/div operations in EX. For each detected hazard it raises a pause request, then tracks the stall until the data or result is ready and issues the matching unpause pulse. It sits beside the ID/EX/MEM stages and observes the controller's `pause` and `flush` outputs.

## Interface
Parameters:
- REG_ADDR_W, 5, register-file address width
- MD_CYCLES, 33, EX mul/div latency in cycles (≥2)
- LOAD_TIMEOUT, 255, maximum cycles to wait for load data before forced release (≥2)

Ports:
- Clock and reset: one clock; reset is synchronous and active-high.
  - clk  in  1  clock
  - rst  in  1  synchronous reset, active-high
- Controller outputs:
  - pause  in  1  `ctrl` pause level
  - flush  in  1  `ctrl` flush level
- ID stage:
  - id_rs1, id_rs2  in  REG_ADDR_W  source register addresses
  - id_rs1_used, id_rs2_used  in  1  source is actually read
- EX stage:
  - ex_rd  in  REG_ADDR_W  destination of EX instruction
  - ex_is_load  in  1  EX instruction is a load
  - ex_md_start  in  1  EX instruction is a mul/div (start strobe)
- MEM stage:
  - mem_rvalid  in  1  load data returned from data memory
- Outputs to `ctrl`:
  - id_pause_signal  out  1  pause request, combinational
  - ex_unpause_signal  out  1  mul/div done pulse, registered
  - mem_unpause_signal  out  1  load data ready pulse, registered
- Status:
  - load_timeout_err  out  1  sticky error, registered

## Operation
- FSM states: IDLE, WAIT_LOAD, WAIT_MD.
- Hazard terms:
  - load_use = ex_is_load & ex_rd≠0 & ((id_rs1_used & id_rs1==ex_rd) | (id_rs2_used & id_rs2==ex_rd)).
  - md_hit = ex_md_start.
- id_pause_signal = (state==IDLE) & ~flush & (md_hit | load_use). It is never asserted outside IDLE.
- Transitions out of IDLE (no flush):
  - md_hit → WAIT_MD, counter loaded with MD_CYCLES-1. md_hit has priority over load_use.
  - Otherwise load_use → WAIT_LOAD, counter loaded with LOAD_TIMEOUT-1.
- WAIT_MD:
  - Counter decrements each cycle.
  - At 0: one-cycle ex_unpause_signal pulse, then → IDLE.
- WAIT_LOAD:
  - mem_rvalid → mem_unpause_signal pulse, then → IDLE.
  - Otherwise counter decrements. At 0: mem_unpause_signal pulse, load_timeout_err set, then → IDLE.
- flush=1 in any state:
  - FSM → IDLE, counter cleared, no unpause pulse emitted.
  - id_pause_signal forced 0 that cycle.
  - Flush beats a same-cycle done, rvalid or timeout.
- mem_rvalid seen in IDLE or WAIT_MD is ignored.
- load_timeout_err clears only on rst.
- Counter width is clog2(max(MD_CYCLES, LOAD_TIMEOUT)). It never wraps: decrement stops at 0.

## Timing
- Reset values: state IDLE, counter 0, ex_unpause_signal 0, mem_unpause_signal 0, load_timeout_err 0. id_pause_signal is 0 while rst is high.
- Detection latency: id_pause_signal is high in the same cycle the hazard appears (cycle T). `ctrl` raises pause at T+1.
- Mul/div: entered at edge T+1. ex_unpause_signal is high during cycle T+MD_CYCLES, exactly one cycle wide.
- Load: mem_rvalid sampled high in cycle R → mem_unpause_signal high in cycle R+1, one cycle wide.
- Timeout: no rvalid → mem_unpause_signal high in cycle T+LOAD_TIMEOUT, with load_timeout_err rising the same cycle.
- Back-to-back: a new hazard can be detected in the cycle the unpause pulse is high (state already IDLE).
- rst mid-wait: state returns to IDLE on the next edge and no pulse is emitted.

## Structure
- A shared package/define file gets:
  - the FSM state encodings (HZ_IDLE, HZ_WAIT_LOAD, HZ_WAIT_MD)
  - the register-zero constant
- These sit alongside the existing `true`/`false` defines.
- One natural sub-module: `hz_down_counter` (load, decrement, zero flag, saturating at 0).
- Everything else stays in a single module.

## Test plan
- Load-use, rs1 only: ex_is_load=1, ex_rd=5, id_rs1=5, id_rs1_used=1 → id_pause_signal=1 same cycle, state WAIT_LOAD. mem_rvalid at +3 → mem_unpause_signal single pulse at +4.
- Mul/div hit: ex_md_start=1, MD_CYCLES=4 → id_pause_signal at T, ex_unpause_signal only at T+4. A same-cycle load_use is ignored.
- No false hazards:
  - ex_rd=0 with load, id_rs1=0 → no pause.
  - id_rs2=7 matches but id_rs2_used=0 → no pause.
- Timeout: LOAD_TIMEOUT=8, load-use with no mem_rvalid → mem_unpause_signal at T+8, load_timeout_err=1 sticky until rst.
- Flush collision: in WAIT_MD, flush=1 in the same cycle the counter hits 0 → no ex_unpause_signal, state IDLE. The next md_hit is detected normally.
- Reset mid-wait: rst=1 during WAIT_LOAD, then mem_rvalid=1 → all outputs 0, no mem_unpause_signal.

Source files
------------

// File: rtl/hazard_unit_pkg.sv
// Shared constants and types for the pipeline hazard detector.
package hazard_unit_pkg;

  // Boolean literals used throughout the hazard logic.
  localparam logic TRUE  = 1'b1;
  localparam logic FALSE = 1'b0;

  // Register x0 is hard-wired to zero, so writes to it never create a dependency.
  localparam int REG_ZERO = 0;

  // Stall tracking states.
  typedef enum logic [1:0] {
    HZ_IDLE      = 2'd0,
    HZ_WAIT_LOAD = 2'd1,
    HZ_WAIT_MD   = 2'd2
  } hz_state_t;

  // Larger of two integers, used to size the shared stall counter.
  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/hz_down_counter.sv
// Loadable down counter that saturates at zero; shared by the load and mul/div waits.
module hz_down_counter #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  input  logic             load,
  input  logic [WIDTH-1:0] load_value,
  input  logic             dec,
  output logic [WIDTH-1:0] count,
  output logic             zero
);

  logic [WIDTH-1:0] count_reg;

  // Clear beats load beats decrement; decrement holds once the count reaches zero.
  always_ff @(posedge clk) begin
    if (rst || clear) begin
      count_reg <= '0;
    end else if (load) begin
      count_reg <= load_value;
    end else if (dec && (count_reg != '0)) begin
      count_reg <= count_reg - WIDTH'(1);
    end
  end

  assign count = count_reg;
  assign zero  = (count_reg == '0);

endmodule

// File: rtl/hazard_unit.sv
// Detects load-use and mul/div hazards, requests a pause, and issues the
// matching unpause pulse once the stalled result is available.
module hazard_unit
  import hazard_unit_pkg::*;
#(
  parameter int REG_ADDR_W   = 5,
  parameter int MD_CYCLES    = 33,
  parameter int LOAD_TIMEOUT = 255
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  pause,
  input  logic                  flush,
  input  logic [REG_ADDR_W-1:0] id_rs1,
  input  logic [REG_ADDR_W-1:0] id_rs2,
  input  logic                  id_rs1_used,
  input  logic                  id_rs2_used,
  input  logic [REG_ADDR_W-1:0] ex_rd,
  input  logic                  ex_is_load,
  input  logic                  ex_md_start,
  input  logic                  mem_rvalid,
  output logic                  id_pause_signal,
  output logic                  ex_unpause_signal,
  output logic                  mem_unpause_signal,
  output logic                  load_timeout_err
);

  localparam int CNT_W = $clog2(max_int(MD_CYCLES, LOAD_TIMEOUT));

  hz_state_t        state_reg, state_next;
  logic             ex_unpause_reg, ex_unpause_next;
  logic             mem_unpause_reg, mem_unpause_next;
  logic             err_reg, err_set;
  logic             cnt_clear, cnt_load, cnt_dec, cnt_zero, cnt_done;
  logic [CNT_W-1:0] cnt_load_value, cnt_count;
  logic             load_use, md_hit;
  logic             pause_unused;

  // The controller's pause level is observed but the stall tracking does not need it.
  assign pause_unused = pause;

  assign md_hit   = ex_md_start;
  assign load_use = ex_is_load && (ex_rd != REG_ADDR_W'(REG_ZERO)) &&
                    ((id_rs1_used && (id_rs1 == ex_rd)) ||
                     (id_rs2_used && (id_rs2 == ex_rd)));

  // Requests are only raised from IDLE, so one stall produces exactly one request.
  assign id_pause_signal = (state_reg == HZ_IDLE) && !flush && !rst && (md_hit || load_use);

  // The wait finishes on the cycle the decrement lands on zero, so the pulse
  // (registered) appears exactly N cycles after detection.
  assign cnt_done = cnt_zero || (cnt_count == CNT_W'(1));

  hz_down_counter #(
    .WIDTH(CNT_W)
  ) u_counter (
    .clk        (clk),
    .rst        (rst),
    .clear      (cnt_clear),
    .load       (cnt_load),
    .load_value (cnt_load_value),
    .dec        (cnt_dec),
    .count      (cnt_count),
    .zero       (cnt_zero)
  );

  // Next-state and counter control; flush abandons any wait without a pulse.
  always_comb begin
    state_next       = state_reg;
    cnt_clear        = FALSE;
    cnt_load         = FALSE;
    cnt_load_value   = '0;
    cnt_dec          = FALSE;
    ex_unpause_next  = FALSE;
    mem_unpause_next = FALSE;
    err_set          = FALSE;
    if (flush) begin
      state_next = HZ_IDLE;
      cnt_clear  = TRUE;
    end else begin
      case (state_reg)
        HZ_IDLE: begin
          if (md_hit) begin
            state_next     = HZ_WAIT_MD;
            cnt_load       = TRUE;
            cnt_load_value = CNT_W'(MD_CYCLES - 1);
          end else if (load_use) begin
            state_next     = HZ_WAIT_LOAD;
            cnt_load       = TRUE;
            cnt_load_value = CNT_W'(LOAD_TIMEOUT - 1);
          end
        end
        HZ_WAIT_MD: begin
          cnt_dec = TRUE;
          if (cnt_done) begin
            ex_unpause_next = TRUE;
            state_next      = HZ_IDLE;
          end
        end
        HZ_WAIT_LOAD: begin
          if (mem_rvalid) begin
            mem_unpause_next = TRUE;
            cnt_clear        = TRUE;
            state_next       = HZ_IDLE;
          end else begin
            cnt_dec = TRUE;
            if (cnt_done) begin
              mem_unpause_next = TRUE;
              err_set          = TRUE;
              state_next       = HZ_IDLE;
            end
          end
        end
        default: begin
          state_next = HZ_IDLE;
          cnt_clear  = TRUE;
        end
      endcase
    end
  end

  // State, unpause pulses and the sticky timeout flag.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg       <= HZ_IDLE;
      ex_unpause_reg  <= FALSE;
      mem_unpause_reg <= FALSE;
      err_reg         <= FALSE;
    end else begin
      state_reg       <= state_next;
      ex_unpause_reg  <= ex_unpause_next;
      mem_unpause_reg <= mem_unpause_next;
      err_reg         <= err_reg || err_set;
    end
  end

  assign ex_unpause_signal  = ex_unpause_reg;
  assign mem_unpause_signal = mem_unpause_reg;
  assign load_timeout_err   = err_reg;

endmodule
